uart_rx_ctrl_param: RTL
=======================

Name: uart_rx_ctrl_param

Overview:
Parametrised successor to the fixed 8-bit UART receive controller. It integrates the RX state machine, the edge and bit counters, 3-sample majority voting, the deserializer and the parity/stop checks in one block. It supports runtime-selectable oversampling, optional odd/even parity and 1 or 2 stop bits. It sits between the RX pad synchroniser and the RX-side clock-domain-crossing logic.

Parameters:
DATA_WIDTH, 8, payload bits per frame (legal 5..9).
PRESCALE_W, 6, width of the prescale input; max oversampling is 2^PRESCALE_W-2.

Ports:
Clk  input  1  receive (oversampling) clock
RST  input  1  asynchronous, active-high reset
RX_IN  input  1  serial line, already synchronised; idle = 1
prescale  input  PRESCALE_W  oversampling ratio P; even, >= 4
PAR_EN  input  1  1 = parity bit present
PAR_TYP  input  1  0 = even, 1 = odd
STOP2  input  1  1 = two stop bits
P_DATA  output  DATA_WIDTH  received payload, LSB first on line
data_valid  output  1  one-cycle pulse, P_DATA good
par_err  output  1  one-cycle pulse, parity mismatch
stp_err  output  1  one-cycle pulse, stop bit sampled 0
busy  output  1  high in any state except IDLE

Behaviour:
- Reset (RST=1, async): state IDLE; counters 0; P_DATA=0; data_valid=par_err=stp_err=busy=0.
- Config latch: prescale, PAR_EN, PAR_TYP and STOP2 are captured on the IDLE->START transition. Changes during a frame have no effect on that frame.
- edge_cnt runs 0..P-1, then wraps to 0 and increments bit_cnt. Both counters clear in IDLE.
- Sampling: RX_IN is captured at edge_cnt = P/2-1, P/2 and P/2+1. The bit value is the majority of the three. It is valid from edge_cnt = P/2+2.
- States:
  - IDLE: RX_IN=0 -> START. Counters start from 0 on the next cycle.
  - START: at edge_cnt=P-1, sampled bit 1 (glitch) -> IDLE with no pulse; otherwise -> DATA.
  - DATA: the sampled bit shifts into the deserializer MSB-side, giving an LSB-first frame. After DATA_WIDTH bits, at edge_cnt=P-1: PAR_EN -> PARITY, else -> STOP.
  - PARITY: expected bit = ^data (even) or ~^data (odd). The mismatch is registered. At edge_cnt=P-1 -> STOP.
  - STOP: the first stop bit is sampled. With STOP2=1, the block waits a full bit (edge_cnt=P-1) and samples the second. After the final stop sample is valid (edge_cnt=P/2+2) -> VALID. This does not wait for the bit end, which leaves a half-bit of resync slack.
  - VALID (one cycle): P_DATA is updated only if there is no error. Exactly one of the following is pulsed:
    - data_valid, if parity and stop are both OK;
    - par_err, on a parity mismatch (wins over stp_err);
    - stp_err, on a stop error only.
    - Then -> START if RX_IN=0 (back-to-back frame, counters reset), else -> IDLE.
- P_DATA holds its last good value between frames and on errored frames.
- Latency: data_valid rises P/2+3 cycles after the first Clk edge of the final stop bit's centre window start. It is registered and aligned with P_DATA.
- A stop error in a 2-stop frame is flagged if either stop sample is 0.
- Reset asserted mid-frame aborts immediately with no pulse. After release, a low RX_IN is treated as a new start bit.
- Illegal prescale (odd or <4) is undefined; the verification environment must not drive it.

Optional Feature:
- Macro: UART_RX_BREAK_DET_EN.
- Defined: adds output break_det (1 bit, reset 0).
  - A frame whose start, all data, parity (if enabled) and stop samples are all 0 pulses break_det in VALID instead of stp_err.
  - The FSM then enters BREAK_WAIT and stays there until RX_IN=1 for one full sample. Only then does it return to IDLE, so no spurious start is detected during a long break.
- Undefined: no port and no extra state. An all-zero frame reports stp_err and then behaves as any other frame.

Test Plan:
1. P=8, DATA_WIDTH=8, no parity, frame 0xA5 -> data_valid pulse, P_DATA=0xA5, busy low within 1 cycle after VALID.
2. P=16, PAR_EN=1, PAR_TYP=0, 0x3C with parity bit 1 (wrong) -> par_err pulse, no data_valid, P_DATA keeps previous value.
3. P=8, start low for 3 cycles then high -> no pulses, return to IDLE, then a valid 0x5A frame is received correctly.
4. P=32, STOP2=1, 0x81 with second stop bit 0 -> stp_err pulse only. Repeat with both stop bits 1 -> data_valid, P_DATA=0x81.
5. Back-to-back frames 0x11, 0x22 with zero idle, plus a single-cycle glitch at a data sample point -> two data_valid pulses, values correct (majority vote).
6. Reset asserted mid-DATA, then released with RX_IN high -> all outputs 0, IDLE; the next frame 0xFF is received. With UART_RX_BREAK_DET_EN, 2 frames of continuous 0 -> one break_det pulse, no data_valid until RX_IN returns high and a new frame arrives.

Source files
------------

// File: rtl/uart_rx_ctrl_param.sv
// uart_rx_ctrl_param: UART receive controller with a runtime-selectable
// oversampling ratio, optional odd/even parity and one or two stop bits.
// It combines the RX FSM, the edge and bit counters, 3-sample majority
// voting, the LSB-first deserializer and the parity/stop checks.
// Ports:
//   Clk        oversampling clock
//   RST        asynchronous active-high reset
//   RX_IN      synchronised serial line, idle high
//   prescale   oversampling ratio P (even, >= 4)
//   PAR_EN     parity bit present
//   PAR_TYP    0 even, 1 odd
//   STOP2      two stop bits
//   P_DATA     last good payload
//   data_valid one-cycle pulse on a good frame
//   par_err    one-cycle pulse on a parity mismatch
//   stp_err    one-cycle pulse on a stop bit sampled 0
//   busy       high whenever the FSM is not idle
// Optional macro UART_RX_BREAK_DET_EN adds break_det and the BREAK_WAIT
// state that holds off start detection during a long line break.
module uart_rx_ctrl_param #(
  parameter int DATA_WIDTH = 8,
  parameter int PRESCALE_W = 6
) (
  input  logic                  Clk,
  input  logic                  RST,
  input  logic                  RX_IN,
  input  logic [PRESCALE_W-1:0] prescale,
  input  logic                  PAR_EN,
  input  logic                  PAR_TYP,
  input  logic                  STOP2,
  output logic [DATA_WIDTH-1:0] P_DATA,
  output logic                  data_valid,
  output logic                  par_err,
  output logic                  stp_err,
`ifdef UART_RX_BREAK_DET_EN
  output logic                  break_det,
`endif
  output logic                  busy
);

  localparam int PW = PRESCALE_W;
  localparam int BW = 4;
  localparam logic [PW-1:0] ONE = PW'(1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PARITY,
    S_STOP,
`ifdef UART_RX_BREAK_DET_EN
    S_VALID,
    S_BRK
`else
    S_VALID
`endif
  } state_t;

  state_t r_state;
  state_t w_next;

  logic [PW-1:0]         r_p;
  logic [PW-1:0]         r_edge;
  logic [BW-1:0]         r_bit;
  logic                  r_par_en;
  logic                  r_par_typ;
  logic                  r_stop2;
  logic                  r_s0;
  logic                  r_s1;
  logic                  r_s2;
  logic [DATA_WIDTH-1:0] r_shift;
  logic [DATA_WIDTH-1:0] r_pdata;
  logic                  r_par_bad;
  logic                  r_stp_bad;
  logic                  r_dv;
  logic                  r_pe;
  logic                  r_se;

  logic [PW-1:0] w_half;
  logic [PW-1:0] w_hm1;
  logic [PW-1:0] w_hp1;
  logic [PW-1:0] w_last;
  logic [PW:0]   w_h2;
  logic          w_at_end;
  logic          w_chk_pt;
  logic          w_s2_now;
  logic          w_bit;
  logic          w_par_exp;
  logic          w_stop_last;
  logic          w_stop_done;
  logic          w_stp_fail;
  logic          w_in_frame;
  logic          w_new_frame;

  assign w_half   = {1'b0, r_p[PW-1:1]};
  assign w_hm1    = w_half - ONE;
  assign w_hp1    = w_half + ONE;
  assign w_last   = r_p - ONE;
  assign w_h2     = {1'b0, w_half} + (PW+1)'(2);
  assign w_at_end = (r_edge == w_last);

  // For P=4 the P/2+2 point falls outside the bit, so the
  // final stop check moves to the last edge of the bit.
  assign w_chk_pt = (w_h2 > {1'b0, w_last}) ? w_at_end
                  : ({1'b0, r_edge} == w_h2);

  // Third sample bypasses its register when read on the
  // same edge it is captured (only happens for P=4).
  assign w_s2_now = (r_edge == w_hp1) ? RX_IN : r_s2;
  assign w_bit    = (r_s0 & r_s1) | (r_s0 & w_s2_now)
                  | (r_s1 & w_s2_now);

  assign w_par_exp   = r_par_typ ? ~(^r_shift) : ^r_shift;
  assign w_stop_last = (r_bit == {{(BW-1){1'b0}}, r_stop2});
  assign w_stop_done = (r_state == S_STOP) && w_stop_last
                     && w_chk_pt;
  assign w_stp_fail  = r_stp_bad | ~w_bit;

  assign w_in_frame  = (r_state == S_START) || (r_state == S_DATA)
                    || (r_state == S_PARITY) || (r_state == S_STOP);
  assign w_new_frame = (w_next == S_START)
                    && ((r_state == S_IDLE) || (r_state == S_VALID));

`ifdef UART_RX_BREAK_DET_EN
  logic r_zero;
  logic r_bd;
  logic w_break;
  assign w_break   = r_zero & ~w_bit;
  assign break_det = r_bd;
`endif

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      S_IDLE: begin
        if (!RX_IN) w_next = S_START;
      end
      S_START: begin
        if (w_at_end) w_next = w_bit ? S_IDLE : S_DATA;
      end
      S_DATA: begin
        if (w_at_end && (r_bit == BW'(DATA_WIDTH-1)))
          w_next = r_par_en ? S_PARITY : S_STOP;
      end
      S_PARITY: begin
        if (w_at_end) w_next = S_STOP;
      end
      S_STOP: begin
        if (w_stop_done) w_next = S_VALID;
      end
      S_VALID: begin
`ifdef UART_RX_BREAK_DET_EN
        if (r_bd) w_next = S_BRK;
        else w_next = RX_IN ? S_IDLE : S_START;
`else
        w_next = RX_IN ? S_IDLE : S_START;
`endif
      end
`ifdef UART_RX_BREAK_DET_EN
      S_BRK: begin
        if (RX_IN) w_next = S_IDLE;
      end
`endif
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge Clk or posedge RST) begin
    if (RST) begin
      r_state   <= S_IDLE;
      r_p       <= '0;
      r_edge    <= '0;
      r_bit     <= '0;
      r_par_en  <= 1'b0;
      r_par_typ <= 1'b0;
      r_stop2   <= 1'b0;
      r_s0      <= 1'b0;
      r_s1      <= 1'b0;
      r_s2      <= 1'b0;
      r_shift   <= '0;
      r_pdata   <= '0;
      r_par_bad <= 1'b0;
      r_stp_bad <= 1'b0;
      r_dv      <= 1'b0;
      r_pe      <= 1'b0;
      r_se      <= 1'b0;
`ifdef UART_RX_BREAK_DET_EN
      r_zero    <= 1'b0;
      r_bd      <= 1'b0;
`endif
    end else begin
      r_state <= w_next;
      r_dv    <= 1'b0;
      r_pe    <= 1'b0;
      r_se    <= 1'b0;
`ifdef UART_RX_BREAK_DET_EN
      r_bd    <= 1'b0;
`endif
      if (w_new_frame) begin
        r_p       <= prescale;
        r_par_en  <= PAR_EN;
        r_par_typ <= PAR_TYP;
        r_stop2   <= STOP2;
        r_edge    <= '0;
        r_bit     <= '0;
        r_par_bad <= 1'b0;
        r_stp_bad <= 1'b0;
`ifdef UART_RX_BREAK_DET_EN
        r_zero    <= 1'b1;
`endif
      end else if (w_in_frame) begin
        r_edge <= w_at_end ? '0 : r_edge + ONE;
        if (r_edge == w_hm1) r_s0 <= RX_IN;
        if (r_edge == w_half) r_s1 <= RX_IN;
        if (r_edge == w_hp1) r_s2 <= RX_IN;
`ifdef UART_RX_BREAK_DET_EN
        if (w_at_end && (r_state != S_STOP || !w_stop_last))
          r_zero <= r_zero & ~w_bit;
`endif
        unique case (1'b1)
          (r_state == S_START) && w_at_end: begin
            r_bit <= '0;
          end
          (r_state == S_DATA) && w_at_end: begin
            r_shift <= {w_bit, r_shift[DATA_WIDTH-1:1]};
            r_bit   <= (r_bit == BW'(DATA_WIDTH-1)) ? '0
                     : r_bit + BW'(1);
          end
          (r_state == S_PARITY) && w_at_end: begin
            r_par_bad <= w_bit ^ w_par_exp;
            r_bit     <= '0;
          end
          w_stop_done: begin
`ifdef UART_RX_BREAK_DET_EN
            if (w_break) r_bd <= 1'b1;
            else if (r_par_bad) r_pe <= 1'b1;
`else
            if (r_par_bad) r_pe <= 1'b1;
`endif
            else if (w_stp_fail) r_se <= 1'b1;
            else begin
              r_dv    <= 1'b1;
              r_pdata <= r_shift;
            end
          end
          (r_state == S_STOP) && w_at_end && !w_stop_last: begin
            r_stp_bad <= ~w_bit;
            r_bit     <= r_bit + BW'(1);
          end
          default: begin
          end
        endcase
      end else begin
        r_edge <= '0;
        r_bit  <= '0;
      end
    end
  end

  assign P_DATA     = r_pdata;
  assign data_valid = r_dv;
  assign par_err    = r_pe;
  assign stp_err    = r_se;
  assign busy       = (r_state != S_IDLE);

endmodule
